clockdiv_prog: RTL and testbench

//  Runtime-programmable integer clock divider; the next generation of the fixed divide-by-4 divider.

---
 rtl/clockdiv_pkg.sv | 12 +
 rtl/clockdiv_prog.sv | 106 ++++++++++
 tb/tb_clockdiv_prog.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/clockdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Holds the minimum legal divisor, default width and divisor clamp.
package clockdiv_pkg;

  localparam int DIV_WIDTH_DEF = 16;
  localparam logic [31:0] MIN_DIV = 32'd2;

  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/clockdiv_prog.sv
// Runtime-programmable integer divider: divided clock plus rise/tc enables.
// Ports: original_clk, reset_n, enable, sync_clr, div_in, div_load -> new_clk, rise_en, tc, div_busy, div_err.
import clockdiv_pkg::*;

module clockdiv_prog #(
  parameter int DIV_WIDTH   = DIV_WIDTH_DEF,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                 original_clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 sync_clr,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic                 div_load,
  output logic                 new_clk,
  output logic                 rise_en,
  output logic                 tc,
  output logic                 div_busy,
  output logic                 div_err
);

  localparam logic [DIV_WIDTH-1:0] ONE  = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DEFD = DIV_WIDTH'(DEFAULT_DIV);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] dact_q, dact_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 nclk_q, nclk_d;
  logic                 rise_q, rise_d;
  logic                 tc_q, tc_d;

  logic [DIV_WIDTH-1:0] ld_val;
  logic [DIV_WIDTH-1:0] nxt_div;
  logic [DIV_WIDTH-1:0] half_d;
  logic                 wrap;
  logic                 run;

  always_comb begin
    ld_val  = DIV_WIDTH'(clamp_div(32'(div_in)));
    wrap    = enable && (cnt_q == dact_q - ONE);
    nxt_div = div_load ? ld_val
            : (busy_q ? pend_q : dact_q);
    run     = enable && !sync_clr;

    cnt_d  = cnt_q;
    dact_d = dact_q;
    pend_d = pend_q;
    busy_d = busy_q;
    err_d  = err_q;

    if (div_load) begin
      pend_d = ld_val;
      busy_d = 1'b1;
      err_d  = (ld_val != div_in);
    end

    // A clear or a wrap is a period boundary:
    // any pending (or same-cycle) divisor lands here.
    if (sync_clr || wrap) begin
      cnt_d  = '0;
      dact_d = nxt_div;
      busy_d = 1'b0;
    end else if (enable) begin
      cnt_d = cnt_q + ONE;
    end

    // Outputs are registered copies of what the
    // next count implies; pulses drop on frozen edges.
    half_d = dact_d >> 1;
    nclk_d = (cnt_d >= half_d);
    rise_d = run && (cnt_d == half_d)
                 && (cnt_q + ONE == half_d);
    tc_d   = run && (cnt_d == dact_d - ONE);
  end

  always_ff @(posedge original_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      dact_q <= DEFD;
      pend_q <= DEFD;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
      nclk_q <= 1'b0;
      rise_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dact_q <= dact_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      err_q  <= err_d;
      nclk_q <= nclk_d;
      rise_q <= rise_d;
      tc_q   <= tc_d;
    end
  end

  assign new_clk  = nclk_q;
  assign rise_en  = rise_q;
  assign tc       = tc_q;
  assign div_busy = busy_q;
  assign div_err  = err_q;

endmodule

// File: tb/tb_clockdiv_prog.sv
// Self-checking bench for clockdiv_prog.
// Directed scenarios then randomized traffic against a cycle model.
module tb_clockdiv_prog;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, clr, ld;
  logic [15:0] din;
  logic        nclk, rise, tc, busy, err;

  int checks = 0;
  int errors = 0;

  int m_cnt, m_d;
  int pq[$];
  bit m_err, m_rise, m_tc;

  clockdiv_prog #(.DIV_WIDTH(16), .DEFAULT_DIV(2)) dut (
    .original_clk(clk),
    .reset_n     (rst_n),
    .enable      (en),
    .sync_clr    (clr),
    .div_in      (din),
    .div_load    (ld),
    .new_clk     (nclk),
    .rise_en     (rise),
    .tc          (tc),
    .div_busy    (busy),
    .div_err     (err)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("new_clk", nclk, logic'(m_cnt >= m_d / 2));
    chk("rise_en", rise, logic'(m_rise));
    chk("tc", tc, logic'(m_tc));
    chk("div_busy", busy, logic'(pq.size() != 0));
    chk("div_err", err, logic'(m_err));
  endtask

  task automatic model_reset();
    m_cnt = 0; m_d = 2; pq.delete();
    m_err = 0; m_rise = 0; m_tc = 0;
  endtask

  // One master edge, from the rules: the period ends when the
  // last count is reached while enabled; the last load wins.
  task automatic model_step(input bit e, input bit c, input bit l, input int v);
    int cv, prev;
    bit counted, wrap;
    cv = (v < 2) ? 2 : v;
    if (l) m_err = (v < 2);
    prev = m_cnt;
    counted = e && !c;
    wrap = e && (m_cnt == m_d - 1);
    if (c || wrap) begin
      if (l) m_d = cv;
      else if (pq.size() != 0) m_d = pq[$];
      pq.delete();
      m_cnt = 0;
    end else begin
      if (e) m_cnt++;
      if (l) pq.push_back(cv);
    end
    m_rise = counted && (m_cnt == m_d / 2) && (prev == m_d / 2 - 1);
    m_tc = counted && (m_cnt == m_d - 1);
  endtask

  task automatic cyc(input bit e, input bit c, input bit l, input int v);
    en = e; clr = c; ld = l; din = 16'(v);
    @(posedge clk);
    model_step(e, c, l, v);
    @(negedge clk);
    check_all();
    ld = 1'b0; clr = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int rises;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; ld = 1'b0; din = '0;
    model_reset();
    @(negedge clk);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // default divide by 2
    rises = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 0);
      if (rise) rises++;
    end
    checks++;
    assert (rises == 4) else begin
      errors++;
      $error("FAIL d2_rises obs=%0d exp=4", rises);
    end

    // load 5 mid-period, busy until the wrap
    cyc(1, 0, 1, 5);
    chk("busy_after_load", busy, 1'b1);
    run(14);

    // clamp to 2 and sticky error, then 8
    cyc(1, 0, 1, 0);
    chk("err_set", err, 1'b1);
    run(6);
    cyc(1, 0, 1, 8);
    chk("err_clr", err, 1'b0);
    run(12);

    // freeze at cnt=3 with D=8
    cyc(1, 1, 0, 0);
    run(3);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0);
    run(10);

    // two loads before the wrap; last wins
    cyc(1, 1, 1, 8);
    cyc(1, 0, 1, 6);
    cyc(1, 0, 1, 10);
    run(20);
    // load coincident with the tc cycle
    while (!tc) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 3);
    chk("busy_on_wrap_load", busy, 1'b0);
    run(9);

    // freeze while loading: load still captured
    cyc(0, 0, 1, 7);
    chk("busy_frozen_load", busy, 1'b1);
    run(16);

    // async reset mid-period, then clear with pending 4
    run(2);
    do_reset();
    cyc(1, 0, 1, 4);
    cyc(1, 1, 0, 0);
    chk("clr_busy", busy, 1'b0);
    run(10);

    // maximum divisor
    cyc(1, 1, 1, 65535);
    run(40);
    cyc(0, 1, 1, 1);
    run(6);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit e, c, l;
      int v, r;
      if ($urandom_range(0, 599) == 0) do_reset();
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 59) == 0);
      l = ($urandom_range(0, 14) == 0);
      r = $urandom_range(0, 19);
      v = (r == 0) ? 0 : (r == 1) ? 1 : $urandom_range(2, 13);
      cyc(e, c, l, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
